// File: rtl/apb_cmd_master.sv
// apb_cmd_master: single-outstanding command-to-APB master; optional ACCESS timeout under APB_MST_TIMEOUT_EN
`ifndef P_ADDR_W
`define P_ADDR_W 32
`endif
`ifndef P_DATA_W
`define P_DATA_W 32
`endif
`ifndef P_STRB_W
`define P_STRB_W 4
`endif

module apb_cmd_master #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [`P_ADDR_W-1:0] cmd_addr,
    input  logic [`P_DATA_W-1:0] cmd_wdata,
    input  logic [`P_STRB_W-1:0] cmd_wstrb,
    input  logic                 cmd_write,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [`P_DATA_W-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic [`P_ADDR_W-1:0] paddr,
    output logic                 psel,
    output logic                 penable,
    output logic                 pwrite,
    output logic [`P_DATA_W-1:0] pwdata,
    output logic [`P_STRB_W-1:0] pwstrb,
    input  logic                 pready,
    input  logic [`P_DATA_W-1:0] prdata,
    input  logic                 pslverr
);
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
    state_t state, state_nx;
    logic accept;
    logic abort;

    assign accept    = cmd_valid && cmd_ready;
    assign cmd_ready = state == IDLE;
    assign psel      = state == SETUP || state == ACCESS;
    assign penable   = state == ACCESS;
    assign rsp_valid = state == RESP;

`ifdef APB_MST_TIMEOUT_EN
    localparam int CW = TIMEOUT_CYC > 255 ? $clog2(TIMEOUT_CYC + 1) : 8;
    logic [CW-1:0] cnt;
    logic          timeout_q;

    // abort on the wait cycle that brings the stall count up to TIMEOUT_CYC
    assign abort       = state == ACCESS && !pready && cnt == CW'(TIMEOUT_CYC - 1);
    assign rsp_timeout = timeout_q;

    // stall counter: zeroed when a command is taken, advanced per unready ACCESS cycle
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            cnt <= '0;
        else if (accept)
            cnt <= '0;
        else if (state == ACCESS && !pready && !abort)
            cnt <= cnt + 1'b1;
    end

    // timeout flag set by an abort, cleared by a normal completion
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            timeout_q <= 1'b0;
        else if (state == ACCESS && pready)
            timeout_q <= 1'b0;
        else if (abort)
            timeout_q <= 1'b1;
    end
`else
    localparam int unused_timeout_cyc = TIMEOUT_CYC;
    assign abort       = 1'b0;
    assign rsp_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = cmd_valid ? SETUP : IDLE;
            SETUP:   state_nx = ACCESS;
            ACCESS:  state_nx = (pready || abort) ? RESP : ACCESS;
            default: state_nx = rsp_ready ? IDLE : RESP;
        endcase
    end

    // APB request fields captured on accept; response fields captured on completion or abort
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr     <= '0;
            pwrite    <= 1'b0;
            pwdata    <= '0;
            pwstrb    <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (accept) begin
                paddr  <= cmd_addr;
                pwrite <= cmd_write;
                pwdata <= cmd_wdata;
                pwstrb <= cmd_write ? cmd_wstrb : '0;
            end
            if (state == ACCESS && pready) begin
                rsp_rdata <= pwrite ? '0 : prdata;
                rsp_err   <= pslverr;
            end else if (abort) begin
                rsp_rdata <= '0;
                rsp_err   <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: randomized transaction-level checks of apb_cmd_master against a reference model
module tb_apb_cmd_master;
    localparam int TO = 4;
    logic        pclk = 1'b0;
    logic        presetn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        cmd_write = 1'b0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] paddr;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [3:0]  pwstrb;
    logic        pready = 1'b0;
    logic [31:0] prdata = '0;
    logic        pslverr = 1'b0;
    int          total = 0;
    int          passed = 0;
    logic        pend = 1'b0;
    logic [31:0] nxt_a, nxt_d;
    logic [3:0]  nxt_s;
    logic        nxt_w;

    apb_cmd_master #(.TIMEOUT_CYC(TO)) dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb), .cmd_write(cmd_write),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
        .pwdata(pwdata), .pwstrb(pwstrb), .pready(pready), .prdata(prdata), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;

    // one full command: idle -> setup -> (waits+1) access cycles -> response held for hold cycles
    task automatic run_txn(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic w,
                           input int waits, input logic err, input logic [31:0] rd, input int hold, input string tag);
        logic [31:0] exp_rd;
        logic [3:0]  exp_s;
        exp_rd = w ? 32'h0 : rd;
        exp_s  = w ? s : 4'h0;
        total++;
        if ({cmd_ready, rsp_valid, psel, penable} !== 4'b1000)
            $display("FAIL %s idle: got %b exp 1000", tag, {cmd_ready, rsp_valid, psel, penable});
        else passed++;
        cmd_valid = 1'b1; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_write = w;
        @(posedge pclk); #1;
        if (pend) begin
            cmd_addr = nxt_a; cmd_wdata = nxt_d; cmd_wstrb = nxt_s; cmd_write = nxt_w;
        end else begin
            cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_write = 1'($urandom);
        end
        total++;
        if ({psel, penable, cmd_ready, rsp_valid, paddr, pwrite, pwstrb} !== {4'b1000, a, w, exp_s})
            $display("FAIL %s setup: got %b %h %b %h exp 1000 %h %b %h", tag,
                     {psel, penable, cmd_ready, rsp_valid}, paddr, pwrite, pwstrb, a, w, exp_s);
        else passed++;
        @(posedge pclk); #1;
        for (int i = 0; i <= waits; i++) begin
            total++;
            if ({psel, penable, cmd_ready, rsp_valid, paddr, pwrite, pwstrb} !== {4'b1100, a, w, exp_s} || (w && pwdata !== d))
                $display("FAIL %s access%0d: got %b %h %b %h %h exp 1100 %h %b %h %h", tag, i,
                         {psel, penable, cmd_ready, rsp_valid}, paddr, pwrite, pwstrb, pwdata, a, w, exp_s, d);
            else passed++;
            pready  = (i == waits);
            prdata  = (i == waits) ? rd : $urandom;
            pslverr = (i == waits) ? err : 1'($urandom);
            @(posedge pclk); #1;
        end
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
        for (int j = 0; j <= hold; j++) begin
            total++;
            if ({rsp_valid, cmd_ready, psel, penable, rsp_rdata, rsp_err, rsp_timeout} !== {4'b1000, exp_rd, err, 1'b0})
                $display("FAIL %s resp%0d: got %b %h %b %b exp 1000 %h %b 0", tag, j,
                         {rsp_valid, cmd_ready, psel, penable}, rsp_rdata, rsp_err, rsp_timeout, exp_rd, err);
            else passed++;
            rsp_ready = (j == hold);
            @(posedge pclk); #1;
        end
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        total++;
        if ({cmd_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout} !== 7'b1000000 ||
            {paddr, pwdata, pwstrb, rsp_rdata} !== '0)
            $display("FAIL reset: got %b %h %h %h %h exp 1000000 all-zero", {cmd_ready, rsp_valid, psel, penable, pwrite, rsp_err, rsp_timeout},
                     paddr, pwdata, pwstrb, rsp_rdata);
        else passed++;
        @(posedge pclk); #1;
        presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_write();
        run_txn(32'h1000_0004, 32'hDEADBEEF, 4'hF, 1'b1, 0, 1'b0, 32'hA5A5A5A5, 0, "write");
    endtask

    task automatic test_read_wait();
        run_txn(32'h1000_0008, 32'h0, 4'hF, 1'b0, 5, 1'b0, 32'h12345678, 0, "read_wait");
    endtask

    task automatic test_slverr();
        run_txn(32'h1000_000C, 32'h0, 4'h3, 1'b0, 1, 1'b1, 32'hCAFEF00D, 1, "slverr");
    endtask

    task automatic test_back_to_back();
        pend  = 1'b1;
        nxt_a = 32'h2000_0010; nxt_d = 32'h0BADF00D; nxt_s = 4'h5; nxt_w = 1'b1;
        run_txn(32'h2000_0000, 32'h0, 4'h0, 1'b0, 0, 1'b0, 32'h76543210, 10, "hold_first");
        pend = 1'b0;
        run_txn(nxt_a, nxt_d, nxt_s, nxt_w, 0, 1'b0, 32'h11111111, 0, "hold_second");
    endtask

    task automatic test_reset_mid();
        cmd_valid = 1'b1; cmd_addr = 32'h3000_0000; cmd_write = 1'b1; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        @(posedge pclk); #1;
        total++;
        if ({psel, penable} !== 2'b11)
            $display("FAIL rst_mid access: got %b exp 11", {psel, penable});
        else passed++;
        #3 presetn = 1'b0;
        #1;
        total++;
        if ({cmd_ready, rsp_valid, psel, penable, pwrite} !== 5'b10000 || {paddr, pwdata, pwstrb} !== '0)
            $display("FAIL rst_mid assert: got %b %h %h %h exp 10000 zeros", {cmd_ready, rsp_valid, psel, penable, pwrite}, paddr, pwdata, pwstrb);
        else passed++;
        @(posedge pclk); @(posedge pclk); #1;
        presetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge pclk); #1;
            total++;
            if ({cmd_ready, rsp_valid, psel} !== 3'b100)
                $display("FAIL rst_mid after%0d: got %b exp 100", i, {cmd_ready, rsp_valid, psel});
            else passed++;
        end
        run_txn(32'h3000_0004, 32'h0, 4'h0, 1'b0, 2, 1'b0, 32'h89ABCDEF, 0, "rst_mid_next");
    endtask

`ifdef APB_MST_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        cmd_valid = 1'b1; cmd_addr = 32'h4000_0000; cmd_write = 1'b0;
        @(posedge pclk); #1;
        cmd_valid = 1'b0; pready = 1'b0; prdata = 32'hFFFFFFFF;
        @(posedge pclk); #1;
        while (psel && n < 20) begin
            n++;
            @(posedge pclk); #1;
        end
        total++;
        if (n !== TO)
            $display("FAIL timeout cycles: got %0d exp %0d", n, TO);
        else passed++;
        total++;
        if ({rsp_valid, penable, rsp_rdata, rsp_err, rsp_timeout} !== {2'b10, 32'h0, 2'b11})
            $display("FAIL timeout resp: got %b %h %b %b exp 10 0 1 1", {rsp_valid, penable}, rsp_rdata, rsp_err, rsp_timeout);
        else passed++;
        rsp_ready = 1'b1;
        @(posedge pclk); #1;
        rsp_ready = 1'b0;
        run_txn(32'h4000_0004, 32'h0, 4'h0, 1'b0, TO - 1, 1'b0, 32'h13579BDF, 0, "timeout_clear");
    endtask
`endif

    task automatic test_random();
        for (int k = 0; k < 30; k++)
            run_txn($urandom, $urandom, 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
                    1'($urandom), $urandom, int'($urandom_range(0, 2)), $sformatf("rand%0d", k));
    endtask

    initial begin
        #2;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_back_to_back();
        test_reset_mid();
`ifdef APB_MST_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/apb_cmd_master.md
APB_CMD_MASTER -- requirements
Module: apb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 255, meaning the maximum ACCESS-phase wait cycles before abort (used only under APB_MST_TIMEOUT_EN).
REQ-002 The block SHALL have port pclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-003 The block SHALL have port presetn, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port cmd_valid, input, 1 bit: command request.
REQ-005 The block SHALL have port cmd_ready, output, 1 bit: command accepted when high together with cmd_valid.
REQ-006 The block SHALL have ports cmd_addr, input, `P_ADDR_W bits; cmd_wdata, input, `P_DATA_W bits; cmd_wstrb, input, `P_STRB_W bits; cmd_write, input, 1 bit (1 = write).
REQ-007 The block SHALL have ports rsp_valid, output, 1 bit; rsp_ready, input, 1 bit; rsp_rdata, output, `P_DATA_W bits; rsp_err, output, 1 bit; rsp_timeout, output, 1 bit.
REQ-008 The block SHALL have the APB master ports paddr, psel, penable, pwrite, pwdata, pwstrb (outputs), and pready, prdata, pslverr (inputs), at the `P_*_W widths.

Function
REQ-009 The FSM SHALL have states IDLE, SETUP, ACCESS and RESP, and SHALL reset to IDLE.
REQ-010 cmd_ready SHALL be 1 only in IDLE; a handshake in IDLE SHALL capture addr/wdata/wstrb/write and move to SETUP on the next edge.
REQ-011 In SETUP, psel=1 and penable=0, and the FSM SHALL move unconditionally to ACCESS.
REQ-012 In ACCESS, psel=1 and penable=1; the FSM SHALL stay in ACCESS while pready=0.
REQ-013 When pready=1 in ACCESS, the block SHALL latch prdata (forced to 0 for writes) and pslverr into rsp_rdata/rsp_err, clear rsp_timeout, and go to RESP.
REQ-014 paddr, pwrite, pwdata and pwstrb SHALL be held stable from SETUP through the completing ACCESS cycle.
REQ-015 pwstrb SHALL be driven as 0 for reads.
REQ-016 In IDLE and RESP, psel and penable SHALL be 0.
REQ-017 In RESP, rsp_valid SHALL be 1 with stable response fields; on rsp_ready=1 the FSM SHALL return to IDLE.
REQ-018 Minimum command-accept-to-rsp_valid latency SHALL be 3 cycles (accept, SETUP, ACCESS with pready=1); back-to-back commands SHALL therefore be at best 4 cycles apart.
REQ-019 rsp_valid and cmd_ready SHALL never be high in the same cycle.
REQ-020 A cmd_valid arriving while the block is busy SHALL be held off (cmd_ready=0) and SHALL NOT be dropped or altered.

Reset
REQ-021 Assertion of presetn low SHALL immediately force the FSM to IDLE and all outputs to 0, except cmd_ready, which SHALL go to 1.
REQ-022 Reset asserted mid-transfer SHALL abort the transfer with no response generated; the first command after reset deassertion SHALL proceed normally.

Configuration
REQ-023 With APB_MST_TIMEOUT_EN defined, an 8+ bit counter SHALL count ACCESS cycles with pready=0.
REQ-024 With APB_MST_TIMEOUT_EN defined, when the counter reaches TIMEOUT_CYC the block SHALL drop psel/penable on the next edge and enter RESP with rsp_err=1, rsp_timeout=1 and rsp_rdata=0.
REQ-025 With APB_MST_TIMEOUT_EN defined, the counter SHALL clear on entry to SETUP.
REQ-026 With APB_MST_TIMEOUT_EN not defined, there SHALL be no counter, the block SHALL wait indefinitely in ACCESS, and rsp_timeout SHALL be tied to 0.

Verification
REQ-027 Write cmd addr=0x1000_0004, wdata=0xDEADBEEF, wstrb=0xF, with pready=1 -> SETUP then ACCESS with stable signals; rsp_valid 3 cycles after accept with rsp_err=0 and rsp_rdata=0.
REQ-028 Read addr=0x1000_0008 with pready low for 5 ACCESS cycles and prdata=0x12345678 -> 5 extra ACCESS cycles, pwstrb=0, rsp_rdata=0x12345678.
REQ-029 Read with pslverr=1 on completion -> rsp_err=1, rsp_timeout=0.
REQ-030 With the macro defined, TIMEOUT_CYC=4 and pready held 0 -> psel drops after 4 ACCESS cycles, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-031 rsp_ready held 0 for 10 cycles while a second cmd_valid is pending -> rsp fields stable, cmd_ready=0, second command accepted only after the response handshake.
REQ-032 presetn pulsed low during ACCESS -> psel/penable=0 immediately, no rsp_valid, next command completes normally.
